// File: rtl/moore_mode_bank_if.sv
// Command/response bundle between the control sequencer (master) and a
// moore_mode_bank instance (slave).
interface moore_mode_bank_if #(
   parameter int CW    = 2,
   parameter int WIDTH = 8
);
   logic             cmd_valid;
   logic [CW-1:0]    cmd_chan;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             resp_valid;
   logic             resp_err;
   logic [WIDTH-1:0] resp_value;

   modport master (
      output cmd_valid, cmd_chan, cmd_op, cmd_data,
      input  resp_valid, resp_err, resp_value
   );

   modport slave (
      input  cmd_valid, cmd_chan, cmd_op, cmd_data,
      output resp_valid, resp_err, resp_value
   );
endinterface

// File: rtl/moore_mode_bank.sv
// Multi-channel Moore mode/apply register bank: each channel keeps a mode,
// a load value and an output value; outputs and responses come from flops.
module moore_mode_bank #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8,
   parameter int WRAP     = 1,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   moore_mode_bank_if.slave          bus,
   output logic [CHANNELS*WIDTH-1:0] o_aout,
   output logic [CHANNELS*3-1:0]     o_state
);
   localparam logic [2:0] OP_APPLY     = 3'b000;
   localparam logic [2:0] OP_LOAD      = 3'b110;
   localparam logic [2:0] OP_APPLY_ALL = 3'b111;

   localparam logic [2:0] M_CLEAR  = 3'b000;
   localparam logic [2:0] M_TOGGLE = 3'b001;
   localparam logic [2:0] M_SET    = 3'b010;
   localparam logic [2:0] M_INC    = 3'b011;
   localparam logic [2:0] M_DEC    = 3'b100;
   localparam logic [2:0] M_LOAD   = 3'b101;

   localparam logic [WIDTH-1:0] ONES  = '1;
   localparam logic [WIDTH-1:0] ZERO  = '0;
   localparam logic [CW:0]      LIMIT = (CW+1)'(CHANNELS);

   logic                w_chan_ok;
   logic                w_is_mode;
   logic                w_is_all;
   logic [2:0]          w_mode_code;
   logic [CHANNELS-1:0] w_hit;
   logic [WIDTH-1:0]    w_after_all [CHANNELS];
   logic [WIDTH-1:0]    w_resp_value;
   logic                w_resp_err;

   logic                r_resp_valid;
   logic                r_resp_err;
   logic [WIDTH-1:0]    r_resp_value;

   assign w_chan_ok   = {1'b0, bus.cmd_chan} < LIMIT;
   assign w_is_all    = bus.cmd_op == OP_APPLY_ALL;
   assign w_is_mode   = (bus.cmd_op != OP_APPLY) && !w_is_all;
   // Mode-op codes 001..110 map onto stored modes 000..101.
   assign w_mode_code = bus.cmd_op - 3'd1;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [WIDTH-1:0] r_aout;
         logic [2:0]       r_mode;
         logic [WIDTH-1:0] r_load;
         logic [WIDTH-1:0] w_applied;
         logic             w_do_apply;
         logic [WIDTH-1:0] w_after;

         always_comb begin
            w_applied = ZERO;
            case (r_mode)
               M_CLEAR:  w_applied = ZERO;
               M_TOGGLE: w_applied = ~r_aout;
               M_SET:    w_applied = ONES;
               M_INC:    w_applied = (r_aout == ONES && WRAP == 0) ? ONES : r_aout + WIDTH'(1);
               M_DEC:    w_applied = (r_aout == ZERO && WRAP == 0) ? ZERO : r_aout - WIDTH'(1);
               M_LOAD:   w_applied = r_load;
               default:  w_applied = ZERO;
            endcase
         end

         assign w_hit[gi]       = bus.cmd_valid && w_chan_ok && (bus.cmd_chan == CW'(gi));
         assign w_do_apply      = (bus.cmd_valid && w_is_all) || (w_hit[gi] && bus.cmd_op == OP_APPLY);
         assign w_after         = w_do_apply ? w_applied : r_aout;
         assign w_after_all[gi] = w_after;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_aout <= ZERO;
               r_mode <= M_CLEAR;
               r_load <= ZERO;
            end else begin
               r_aout <= w_after;
               if (w_hit[gi] && w_is_mode)
                  r_mode <= w_mode_code;
               if (w_hit[gi] && bus.cmd_op == OP_LOAD)
                  r_load <= bus.cmd_data;
            end
         end

         assign o_aout[gi*WIDTH +: WIDTH] = r_aout;
         assign o_state[gi*3 +: 3]        = r_mode;
      end
   endgenerate

   // The response carries the target's value as it will be after this edge.
   always_comb begin
      w_resp_value = ZERO;
      for (int i = 0; i < CHANNELS; i++)
         if (w_hit[i])
            w_resp_value = w_after_all[i];
      if (w_is_all)
         w_resp_value = ZERO;
   end

   assign w_resp_err = !w_is_all && !w_chan_ok;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_value <= ZERO;
      end else begin
         r_resp_valid <= bus.cmd_valid;
         r_resp_err   <= bus.cmd_valid && w_resp_err;
         r_resp_value <= w_resp_value;
      end
   end

   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_value = r_resp_value;
endmodule

// File: tb/tb_moore_mode_bank.sv
// Drives one command stream into three bank configurations (4ch wrap,
// 4ch saturate, 3ch wrap) and checks each against a scoreboard model.
module tb_moore_mode_bank;
   logic       clock;
   logic       reset;
   logic       c_valid;
   logic [1:0] c_chan;
   logic [2:0] c_op;
   logic [7:0] c_data;

   int errors = 0;
   int checks = 0;

   moore_mode_bank_if #(.CW(2), .WIDTH(8)) bus0 ();
   moore_mode_bank_if #(.CW(2), .WIDTH(8)) bus1 ();
   moore_mode_bank_if #(.CW(2), .WIDTH(8)) bus2 ();

   assign bus0.cmd_valid = c_valid;
   assign bus0.cmd_chan  = c_chan;
   assign bus0.cmd_op    = c_op;
   assign bus0.cmd_data  = c_data;
   assign bus1.cmd_valid = c_valid;
   assign bus1.cmd_chan  = c_chan;
   assign bus1.cmd_op    = c_op;
   assign bus1.cmd_data  = c_data;
   assign bus2.cmd_valid = c_valid;
   assign bus2.cmd_chan  = c_chan;
   assign bus2.cmd_op    = c_op;
   assign bus2.cmd_data  = c_data;

   logic [31:0] aout0, aout1;
   logic [23:0] aout2;
   logic [11:0] st0, st1;
   logic [8:0]  st2;

   moore_mode_bank #(.CHANNELS(4), .WIDTH(8), .WRAP(1)) dut0 (
      .clock(clock), .reset(reset), .bus(bus0), .o_aout(aout0), .o_state(st0));
   moore_mode_bank #(.CHANNELS(4), .WIDTH(8), .WRAP(0)) dut1 (
      .clock(clock), .reset(reset), .bus(bus1), .o_aout(aout1), .o_state(st1));
   moore_mode_bank #(.CHANNELS(3), .WIDTH(8), .WRAP(1)) dut2 (
      .clock(clock), .reset(reset), .bus(bus2), .o_aout(aout2), .o_state(st2));

   logic [31:0] aout_a [3];
   logic [11:0] st_a   [3];
   logic        rv_a   [3];
   logic        re_a   [3];
   logic [7:0]  rval_a [3];

   assign aout_a[0] = aout0;
   assign aout_a[1] = aout1;
   assign aout_a[2] = {8'h00, aout2};
   assign st_a[0]   = st0;
   assign st_a[1]   = st1;
   assign st_a[2]   = {3'b000, st2};
   assign rv_a[0]   = bus0.resp_valid;
   assign rv_a[1]   = bus1.resp_valid;
   assign rv_a[2]   = bus2.resp_valid;
   assign re_a[0]   = bus0.resp_err;
   assign re_a[1]   = bus1.resp_err;
   assign re_a[2]   = bus2.resp_err;
   assign rval_a[0] = bus0.resp_value;
   assign rval_a[1] = bus1.resp_value;
   assign rval_a[2] = bus2.resp_value;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          dut;
      time         t;
      logic        err;
      logic [7:0]  val;
      logic [31:0] aout;
      logic [11:0] st;
   } exp_t;

   typedef struct {
      logic [2:0] op;
      logic [1:0] chan;
      logic [7:0] data;
      logic [7:0] e_wrap;
      logic [7:0] e_sat;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;

   logic [7:0] m_aout [3][4];
   logic [2:0] m_mode [3][4];
   logic [7:0] m_load [3][4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int nch_of(input int d);
      return (d == 2) ? 3 : 4;
   endfunction

   function automatic logic [7:0] m_apply(input logic [2:0] mode, input logic [7:0] a,
                                          input logic [7:0] ld, input bit wrap);
      case (mode)
         3'd0: return 8'h00;
         3'd1: return ~a;
         3'd2: return 8'hFF;
         3'd3: return (a == 8'hFF) ? (wrap ? 8'h00 : 8'hFF) : a + 8'd1;
         3'd4: return (a == 8'h00) ? (wrap ? 8'hFF : 8'h00) : a - 8'd1;
         3'd5: return ld;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++)
         for (int c = 0; c < 4; c++) begin
            m_aout[d][c] = 8'h00;
            m_mode[d][c] = 3'd0;
            m_load[d][c] = 8'h00;
         end
   endtask

   task automatic model_cmd(input logic [2:0] op, input logic [1:0] chan, input logic [7:0] data);
      exp_t       e;
      logic [7:0] tmp [4];
      for (int d = 0; d < 3; d++) begin
         e.dut = d;
         e.t   = $time;
         e.err = (op != 3'd7) && (int'(chan) >= nch_of(d));
         if (op == 3'd7) begin
            for (int c = 0; c < nch_of(d); c++)
               tmp[c] = m_apply(m_mode[d][c], m_aout[d][c], m_load[d][c], d != 1);
            for (int c = 0; c < nch_of(d); c++)
               m_aout[d][c] = tmp[c];
         end else if (!e.err) begin
            if (op == 3'd0)
               m_aout[d][chan] = m_apply(m_mode[d][chan], m_aout[d][chan], m_load[d][chan], d != 1);
            else begin
               m_mode[d][chan] = op - 3'd1;
               if (op == 3'd6)
                  m_load[d][chan] = data;
            end
         end
         e.val  = (e.err || op == 3'd7) ? 8'h00 : m_aout[d][chan];
         e.aout = '0;
         e.st   = '0;
         for (int c = 0; c < nch_of(d); c++) begin
            e.aout[c*8 +: 8] = m_aout[d][c];
            e.st[c*3 +: 3]   = m_mode[d][c];
         end
         sb.push_back(e);
      end
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [1:0] chan, input logic [7:0] data);
      @(negedge clock);
      c_valid = 1'b1;
      c_op    = op;
      c_chan  = chan;
      c_data  = data;
      model_cmd(op, chan, data);
      $display("cmd  t=%0t op=%0d chan=%0d data=%h", $time, op, chan, data);
   endtask

   task automatic idle();
      @(negedge clock);
      c_valid = 1'b0;
   endtask

   // Responses of a command driven at one falling edge are due at the next.
   always @(negedge clock) begin
      for (int d = 0; d < 3; d++) begin
         if (rv_a[d]) begin
            if (sb.size() == 0 || sb[0].dut != d) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected dut%0d: got resp_valid=1 expected none", d);
            end else begin
               mon_e = sb.pop_front();
               chk($sformatf("sb_err dut%0d", d),   {31'b0, re_a[d]},   {31'b0, mon_e.err});
               chk($sformatf("sb_val dut%0d", d),   {24'b0, rval_a[d]}, {24'b0, mon_e.val});
               chk($sformatf("sb_aout dut%0d", d),  aout_a[d],          mon_e.aout);
               chk($sformatf("sb_state dut%0d", d), {20'b0, st_a[d]},   {20'b0, mon_e.st});
            end
         end else if (sb.size() > 0 && sb[0].dut == d && sb[0].t < $time) begin
            checks++;
            errors++;
            $display("FAIL resp_missing dut%0d: got resp_valid=0 expected 1", d);
            void'(sb.pop_front());
         end
      end
   end

   vec_t tbl [18];

   initial begin
      tbl[0]  = '{3'd3, 2'd2, 8'h00, 8'h00, 8'h00};
      tbl[1]  = '{3'd0, 2'd2, 8'h00, 8'hFF, 8'hFF};
      tbl[2]  = '{3'd2, 2'd2, 8'h00, 8'hFF, 8'hFF};
      tbl[3]  = '{3'd0, 2'd2, 8'h00, 8'h00, 8'h00};
      tbl[4]  = '{3'd0, 2'd2, 8'h00, 8'hFF, 8'hFF};
      tbl[5]  = '{3'd1, 2'd2, 8'h00, 8'hFF, 8'hFF};
      tbl[6]  = '{3'd0, 2'd2, 8'h00, 8'h00, 8'h00};
      tbl[7]  = '{3'd3, 2'd1, 8'h00, 8'h00, 8'h00};
      tbl[8]  = '{3'd6, 2'd1, 8'h5A, 8'h00, 8'h00};
      tbl[9]  = '{3'd0, 2'd1, 8'h00, 8'h5A, 8'h5A};
      tbl[10] = '{3'd6, 2'd0, 8'hFF, 8'h00, 8'h00};
      tbl[11] = '{3'd0, 2'd0, 8'h00, 8'hFF, 8'hFF};
      tbl[12] = '{3'd4, 2'd0, 8'h00, 8'hFF, 8'hFF};
      tbl[13] = '{3'd0, 2'd0, 8'h00, 8'h00, 8'hFF};
      tbl[14] = '{3'd5, 2'd0, 8'h00, 8'h00, 8'hFF};
      tbl[15] = '{3'd0, 2'd0, 8'h00, 8'hFF, 8'hFE};
      tbl[16] = '{3'd5, 2'd3, 8'h00, 8'h00, 8'h00};
      tbl[17] = '{3'd0, 2'd3, 8'h00, 8'hFF, 8'h00};

      reset   = 1'b1;
      c_valid = 1'b0;
      c_op    = 3'd0;
      c_chan  = 2'd0;
      c_data  = 8'h00;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_aout dut%0d", d),  aout_a[d], 32'h0);
         chk($sformatf("rst_state dut%0d", d), {20'b0, st_a[d]}, 32'h0);
         chk($sformatf("rst_resp dut%0d", d),  {23'b0, rv_a[d], re_a[d], rval_a[d]}, 32'h0);
      end
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         do_cmd(tbl[i].op, tbl[i].chan, tbl[i].data);
         @(posedge clock);
         #1;
         chk($sformatf("tbl%0d_wrap", i), {24'b0, rval_a[0]}, {24'b0, tbl[i].e_wrap});
         chk($sformatf("tbl%0d_sat", i),  {24'b0, rval_a[1]}, {24'b0, tbl[i].e_sat});
      end
      chk("tbl_end_aout_wrap", aout0, 32'hFF005AFF);
      chk("tbl_end_aout_sat",  aout1, 32'h00005AFE);
      chk("tbl_end_state_ch1", {29'b0, st0[5:3]}, 32'd5);

      // Reset arrives while a command is on the bus: it must vanish entirely.
      @(negedge clock);
      c_valid = 1'b1;
      c_op    = 3'd7;
      c_chan  = 2'd1;
      #2;
      reset = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("midrst_aout dut%0d", d),  aout_a[d], 32'h0);
         chk($sformatf("midrst_state dut%0d", d), {20'b0, st_a[d]}, 32'h0);
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++)
         chk($sformatf("midrst_noresp dut%0d", d), {31'b0, rv_a[d]}, 32'h0);
      @(negedge clock);
      reset   = 1'b0;
      c_valid = 1'b0;
      model_reset();

      do_cmd(3'd2, 2'd1, 8'h00);
      do_cmd(3'd3, 2'd2, 8'h00);
      do_cmd(3'd4, 2'd3, 8'h00);
      do_cmd(3'd7, 2'd2, 8'h00);
      @(posedge clock);
      #1;
      chk("all_aout_wrap", aout0, 32'h01FFFF00);
      chk("all_aout_sat",  aout1, 32'h01FFFF00);
      chk("all_resp",      {23'b0, rv_a[0], re_a[0], rval_a[0]}, {23'b0, 1'b1, 1'b0, 8'h00});

      do_cmd(3'd0, 2'd3, 8'h00);
      do_cmd(3'd0, 2'd3, 8'h00);
      @(posedge clock);
      #1;
      chk("b2b_inc_plus2", {24'b0, rval_a[0]}, 32'h03);
      chk("err3ch_resp",   {23'b0, rv_a[2], re_a[2], rval_a[2]}, {23'b0, 1'b1, 1'b1, 8'h00});
      chk("err3ch_aout",   aout_a[2], 32'h00FFFF00);
      chk("err3ch_state",  {20'b0, st_a[2]}, {20'b0, 3'b000, 3'b010, 3'b001, 3'b000});

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0)
            idle();
         else
            do_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end
      idle();
      idle();
      idle();
      chk("sb_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/moore_mode_bank.md
# moore_mode_bank

Parametrised multi-channel Moore mode/apply register bank. It is the next generation of the single-channel 1-bit mode latch: each of CHANNELS channels holds a registered mode and a WIDTH-bit output value. Commands either select a channel's mode or apply that mode to the channel's value. Output values are pure functions of registered state. A one-cycle response port reports each command's result to the control sequencer.

## Interface
- CHANNELS, 4, number of independent channels (1..16)
- WIDTH, 8, output value width per channel (1..32)
- WRAP, 1, INC/DEC behaviour at limits: 1 = wrap modulo 2^WIDTH, 0 = saturate
- CW, derived, max(1, $clog2(CHANNELS)), channel index width
- clock  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command strobe, one command per cycle, no backpressure
- cmd_chan  in  CW  target channel; ignored for APPLY_ALL
- cmd_op  in  3  000 APPLY, 001 MODE_CLEAR, 010 MODE_TOGGLE, 011 MODE_SET, 100 MODE_INC, 101 MODE_DEC, 110 MODE_LOAD, 111 APPLY_ALL
- cmd_data  in  WIDTH  load value, sampled only with MODE_LOAD
- aout  out  CHANNELS*WIDTH  channel values, channel i at [i*WIDTH +: WIDTH]
- state  out  CHANNELS*3  channel modes, channel i at [i*3 +: 3]
- resp_valid  out  1  pulses one cycle after each accepted cmd_valid
- resp_err  out  1  qualified by resp_valid; 1 = cmd_chan >= CHANNELS
- resp_value  out  WIDTH  qualified by resp_valid; target channel's aout after the command (0 on error or APPLY_ALL)

## Operation
- Mode encoding per channel: 000 CLEAR, 001 TOGGLE, 010 SET, 011 INC, 100 DEC, 101 LOAD. Codes 110 and 111 are never stored.
- MODE_x ops: write the target channel's mode register only. aout is unchanged.
- MODE_LOAD also writes the channel's WIDTH-bit load register with cmd_data.
- APPLY: update the target channel's aout using the mode held before this command:
  - CLEAR → 0
  - TOGGLE → ~aout
  - SET → all ones
  - INC → aout+1
  - DEC → aout-1
  - LOAD → load register
- APPLY_ALL: every channel applies its own mode in the same cycle. resp_err = 0.
- A mode change and an apply are always separate commands. A mode selected in cycle n takes effect for an APPLY in cycle n+1 or later.
- INC/DEC when WRAP=0: INC at all-ones holds all-ones; DEC at 0 holds 0. When WRAP=1: all-ones+1 = 0 and 0-1 = all-ones. Arithmetic is unsigned, WIDTH bits, with no carry out.
- Out-of-range cmd_chan (non-power-of-2 CHANNELS): no state changes; resp_valid=1, resp_err=1, resp_value=0.
- cmd_valid=0: no state change; resp_valid=0 next cycle.

## Timing
- Reset (asynchronous, immediate):
  - all aout = 0
  - all state = 000 (CLEAR)
  - all load registers = 0
  - resp_valid = 0, resp_err = 0, resp_value = 0
- Leaving reset: the first edge with reset low may accept a command.
- Command latency: a command sampled on edge n is visible on aout/state after edge n. resp_* is registered at the same edge n, so response and updated value appear together.
- Reset asserted mid-stream: any command in the same cycle is discarded, and no response is produced for it.
- Back-to-back commands at 1 per cycle are fully supported, with no stalls or bubbles. Same-channel back-to-back operations see each other's results (e.g. APPLY, APPLY in INC mode gives +2).
- aout/state are driven directly from flops, with no combinational path from cmd_* to outputs.

## Test plan
- Reset check: drive random commands, assert reset mid-cycle. Required: all aout=0 and all state=000 immediately; no resp_valid on the following edge.
- Per-channel mode sequence, CHANNELS=4, WIDTH=8, ch2:
  - MODE_SET then APPLY → aout[2]=0xFF, resp_value=0xFF
  - MODE_TOGGLE, APPLY → 0x00
  - APPLY again → 0xFF
  - MODE_CLEAR, APPLY → 0x00
  - Other channels remain 0 throughout.
- Mode vs apply separation, ch1: MODE_SET, then MODE_LOAD with cmd_data=0x5A (no APPLY between). Required: aout[1] stays 0 and state[1]=101; a subsequent APPLY → 0x5A.
- WRAP boundaries, WIDTH=8:
  - WRAP=1: LOAD 0xFF, APPLY, MODE_INC, APPLY → 0x00; MODE_DEC, APPLY → 0xFF
  - WRAP=0, same sequence: → 0xFF, then 0xFE; DEC from 0 holds 0
- APPLY_ALL with four channels in modes CLEAR/TOGGLE/SET/INC, all starting at 0x00. Required: aout = {0x01, 0xFF, 0xFF, 0x00} for ch3..ch0 after one edge; resp_err=0, resp_value=0.
- Error channel, CHANNELS=3 with cmd_chan=3 APPLY. Required: resp_valid=1, resp_err=1, resp_value=0; no aout/state change on any channel.
